// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue controller.
// Holds the default operand width, the WAIT_BUSY timeout limit and the
// controller FSM state encoding, plus a small helper for the timeout test.
package mul_pkg;

  localparam int OPW_DEF   = 16;
  // Cycles WAIT_BUSY tolerates without mul_busy before acting.
  localparam int TMO_LIMIT = 3;
  localparam int TMO_W     = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

  // True on the last tolerated cycle of WAIT_BUSY.
  function automatic logic tmo_expired(input logic [TMO_W-1:0] cnt);
    return (cnt == TMO_W'(TMO_LIMIT - 1));
  endfunction

endpackage

// File: rtl/op_fifo.sv
// Operand FIFO for the multiplier issue controller.
// Ports: clk/rst_n (async active-low), push/din write side, pop/dout read side
// (dout shows the head entry combinationally), full/empty flags and count
// (0..DEPTH). Pointers wrap modulo DEPTH; a push while full is accepted only
// when a pop happens in the same cycle, leaving the count unchanged.
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= W'(0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for an external radix-4 Booth multiplier.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_x/in_y operand
// input; mul_x/mul_y/mul_start/mul_busy/mul_z multiplier handshake;
// out_valid/out_ready/out_z result output. Operand pairs queue in op_fifo and
// are issued one at a time in order. Zero operands skip the multiplier. If the
// multiplier never raises busy, the start is retried once and then the result
// is forced to zero so the pipeline cannot lock up.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_x,
  input  logic [OPW-1:0]   in_y,
  output logic [OPW-1:0]   mul_x,
  output logic [OPW-1:0]   mul_y,
  output logic             mul_start,
  input  logic             mul_busy,
  input  logic [2*OPW-1:0] mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] out_z
);

  localparam int FCW = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [OPW-1:0]     mul_x_q, mul_x_d;
  logic [OPW-1:0]     mul_y_q, mul_y_d;
  logic               mul_start_q, mul_start_d;
  logic               out_valid_q, out_valid_d;
  logic [2*OPW-1:0]   out_z_q, out_z_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               retry_q, retry_d;

  logic               fifo_push_s, fifo_pop_s;
  logic               fifo_full_s, fifo_empty_s, fifo_avail_s;
  logic [2*OPW-1:0]   fifo_head_s;
  logic [FCW-1:0]     fifo_count_s;
  logic [OPW-1:0]     head_x_s, head_y_s;

  assign in_ready    = !fifo_full_s;
  assign fifo_push_s = in_valid && in_ready;
  assign head_x_s    = fifo_head_s[2*OPW-1:OPW];
  assign head_y_s    = fifo_head_s[OPW-1:0];
  // Both occupancy views must agree before the head is trusted.
  assign fifo_avail_s = !fifo_empty_s && (fifo_count_s != FCW'(0));

  op_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * OPW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .din   ({in_x, in_y}),
    .pop   (fifo_pop_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Next-state and output logic of the issue FSM.
  always_comb begin
    state_d     = state_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    mul_start_d = 1'b0;
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    tmo_cnt_d   = tmo_cnt_q;
    retry_d     = retry_q;
    fifo_pop_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_avail_s && !out_valid_q) begin
          fifo_pop_s = 1'b1;
          mul_x_d    = head_x_s;
          mul_y_d    = head_y_s;
          tmo_cnt_d  = TMO_W'(0);
          retry_d    = 1'b0;
          if ((head_x_s == OPW'(0)) || (head_y_s == OPW'(0))) begin
            out_z_d     = (2*OPW)'(0);
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            // mul_start is registered, so it rises together with ISSUE.
            mul_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        tmo_cnt_d = TMO_W'(0);
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mul_busy) begin
          tmo_cnt_d = TMO_W'(0);
          state_d   = S_WAIT_DONE;
        end else if (tmo_expired(tmo_cnt_q)) begin
          tmo_cnt_d = TMO_W'(0);
          if (!retry_q) begin
            retry_d     = 1'b1;
            mul_start_d = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            out_z_d     = (2*OPW)'(0);
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!mul_busy) begin
          out_z_d     = mul_z;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_z_d     = (2*OPW)'(0);
        tmo_cnt_d   = TMO_W'(0);
        retry_d     = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mul_x_q     <= OPW'(0);
      mul_y_q     <= OPW'(0);
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= (2*OPW)'(0);
      tmo_cnt_q   <= TMO_W'(0);
      retry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_q     <= retry_d;
    end
  end

  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_start = mul_start_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with an iterative radix-4 Booth
// multiplier model attached and a scoreboard of expected products.
module tb_mul_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] mul_x;
  logic [15:0] mul_y;
  logic        mul_start;
  logic        mul_busy;
  logic [31:0] mul_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  int          start_cnt  = 0;
  int          s0;
  logic        mul_dead   = 1'b0;
  logic        exp_tmo    = 1'b0;
  logic [31:0] sb_q[$];

  mul_issue_ctrl #(.DEPTH(4), .OPW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_start (mul_start),
    .mul_busy  (mul_busy),
    .mul_z     (mul_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Booth partial product for digit i of y, already shifted into place.
  function automatic logic signed [31:0] booth_pp(input logic [15:0] x, input logic [15:0] y, input int i);
    logic [16:0]        ye;
    logic [2:0]         b;
    logic signed [31:0] xs;
    logic signed [31:0] p;
    ye = {y, 1'b0};
    b  = ye[2*i+2 -: 3];
    xs = {{16{x[15]}}, x};
    case (b)
      3'b001, 3'b010: p = xs;
      3'b011:         p = xs <<< 1;
      3'b100:         p = -(xs <<< 1);
      3'b101, 3'b110: p = -xs;
      default:        p = 32'sd0;
    endcase
    return p <<< (2 * i);
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    xs = {{16{x[15]}}, x};
    ys = {{16{y[15]}}, y};
    return xs * ys;
  endfunction

  // Multiplier model: one Booth digit per busy cycle, 8 cycles per product.
  logic        mb_busy;
  logic [2:0]  mb_i;
  logic [31:0] mb_acc;
  logic [15:0] mb_x;
  logic [15:0] mb_y;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_busy <= 1'b0;
      mb_i    <= 3'd0;
      mb_acc  <= 32'd0;
      mb_x    <= 16'd0;
      mb_y    <= 16'd0;
    end else if (!mb_busy) begin
      if (mul_start && !mul_dead) begin
        mb_busy <= 1'b1;
        mb_i    <= 3'd0;
        mb_acc  <= 32'd0;
        mb_x    <= mul_x;
        mb_y    <= mul_y;
      end
    end else begin
      mb_acc <= mb_acc + booth_pp(mb_x, mb_y, int'(mb_i));
      if (mb_i == 3'd7) mb_busy <= 1'b0;
      else              mb_i    <= mb_i + 3'd1;
    end
  end
  assign mul_busy = mb_busy;
  assign mul_z    = mb_acc;

  // Count cycles with mul_start high (each pulse is one cycle).
  always @(negedge clk) begin
    if (mul_start) start_cnt++;
  end

  // Scoreboard: record accepted operands, compare delivered results.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_spurious", 64'(sb_q.size()), 64'd1);
        end else begin
          check_eq("sb_result", 64'(out_z), 64'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        if (exp_tmo || in_x == 16'd0 || in_y == 16'd0) sb_q.push_back(32'd0);
        else                                           sb_q.push_back(ref_prod(in_x, in_y));
      end
    end
  end

  task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
    int n;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check_eq("push_stall", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
    check_eq("drain_idle", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = 16'd0;
    in_y      = 16'd0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mul_start", 64'(mul_start), 64'd0);
    check_eq("rst_mul_xy", 64'({mul_x, mul_y}), 64'd0);
    check_eq("rst_out_z", 64'(out_z), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3 * 5 through the multiplier.
    out_ready = 1'b1;
    s0 = start_cnt;
    push_pair(16'd3, 16'd5);
    wait_drain(100);
    check_eq("p35_starts", 64'(start_cnt - s0), 64'd1);
    check_eq("p35_mul_xy", 64'({mul_x, mul_y}), 64'({16'd3, 16'd5}));

    // -7 * 9 = -63.
    push_pair(16'hFFF9, 16'd9);
    wait_drain(100);

    // Zero shortcut: no start, result two cycles after the push.
    out_ready = 1'b0;
    s0 = start_cnt;
    push_pair(16'd0, 16'd1234);
    check_eq("zero_lat1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("zero_lat2", 64'(out_valid), 64'd1);
    check_eq("zero_z", 64'(out_z), 64'd0);
    out_ready = 1'b1;
    wait_drain(50);
    check_eq("zero_starts", 64'(start_cnt - s0), 64'd0);

    // Five back-to-back pairs with the consumer stalled.
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    push_pair(16'hFFFF, 16'hFFFF);
    push_pair(16'h7FFF, 16'h7FFF);
    push_pair(16'h8000, 16'h8000);
    push_pair(16'h8000, 16'h7FFF);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    repeat (30) begin
      @(posedge clk); #1;
    end
    check_eq("full_hold_ready", 64'(in_ready), 64'd0);
    check_eq("full_hold_valid", 64'(out_valid), 64'd1);
    check_eq("full_hold_z", 64'(out_z), 64'd1);
    out_ready = 1'b1;
    wait_drain(300);

    // Dead multiplier: one retry, then a forced zero result.
    mul_dead = 1'b1;
    exp_tmo  = 1'b1;
    s0 = start_cnt;
    push_pair(16'd2, 16'd3);
    wait_drain(60);
    check_eq("tmo_starts", 64'(start_cnt - s0), 64'd2);
    mul_dead = 1'b0;
    exp_tmo  = 1'b0;

    // Asynchronous reset while the multiplier is busy.
    out_ready = 1'b0;
    push_pair(16'd4, 16'd4);
    push_pair(16'd5, 16'd5);
    for (int n = 0; n < 20; n++) begin
      if (mul_busy) break;
      @(posedge clk); #1;
    end
    check_eq("rst_mid_busy", 64'(mul_busy), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("amid_out_valid", 64'(out_valid), 64'd0);
    check_eq("amid_out_z", 64'(out_z), 64'd0);
    check_eq("amid_mul_xy", 64'({mul_x, mul_y}), 64'd0);
    check_eq("amid_mul_start", 64'(mul_start), 64'd0);
    check_eq("amid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    s0 = start_cnt;
    @(posedge clk); #1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    check_eq("post_rst_starts", 64'(start_cnt - s0), 64'd0);
    out_ready = 1'b1;
    push_pair(16'd6, 16'd7);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
